// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-byte instruction fetch/decode front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F0    = 2'd1,
    F1    = 2'd2,
    ISSUE = 2'd3
  } state_t;

  localparam int INSTR_BYTES = 2;
  localparam int FIELD_W     = 2;
  localparam int RSV_W       = 4;

  // Field positions: byte0 = {opcode, alu_op, wr_addr, rs1}, byte1 = {rs2, imm, reserved}
  localparam int B0_OPCODE_LSB = 6;
  localparam int B0_ALU_LSB    = 4;
  localparam int B0_WR_LSB     = 2;
  localparam int B0_RS1_LSB    = 0;
  localparam int B1_RS2_LSB    = 6;
  localparam int B1_IMM_LSB    = 4;
  localparam int B1_RSV_LSB    = 0;

  localparam logic [3:0] RESERVED_MASK = 4'hF;

endpackage

// File: rtl/instr_decode.sv
// Combinational field slicer for one two-byte instruction; any set reserved
// bit in byte1 flags the instruction as illegal.
module instr_decode
  import fetch_pkg::*;
(
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  output logic [1:0] opcode,
  output logic [1:0] alu_op,
  output logic [1:0] wr_addr,
  output logic [1:0] rs1_addr,
  output logic [1:0] rs2_addr,
  output logic [1:0] immediate,
  output logic       dec_illegal
);

  assign opcode      = byte0[B0_OPCODE_LSB +: FIELD_W];
  assign alu_op      = byte0[B0_ALU_LSB +: FIELD_W];
  assign wr_addr     = byte0[B0_WR_LSB +: FIELD_W];
  assign rs1_addr    = byte0[B0_RS1_LSB +: FIELD_W];
  assign rs2_addr    = byte1[B1_RS2_LSB +: FIELD_W];
  assign immediate   = byte1[B1_IMM_LSB +: FIELD_W];
  assign dec_illegal = |(byte1[B1_RSV_LSB +: RSV_W] & RESERVED_MASK);

endmodule

// File: rtl/fetch_decode_unit.sv
// Front-end fetch/decode stage: fetches two bytes per instruction, presents
// registered decoded fields downstream, and honours redirects from any state.
module fetch_decode_unit
  import fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_valid,
  output logic       dec_valid,
  input  logic       dec_ready,
  output logic [7:0] dec_pc,
  output logic [1:0] opcode,
  output logic [1:0] alu_op,
  output logic [1:0] wr_addr,
  output logic [1:0] rs1_addr,
  output logic [1:0] rs2_addr,
  output logic [1:0] immediate,
  output logic       dec_illegal,
  input  logic       redirect,
  input  logic [7:0] redirect_pc
);

  localparam logic [7:0] PC_STEP = 8'(INSTR_BYTES);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] pc_r;
  logic [7:0] byte0_r;
  logic [7:0] pc_plus1_s;
  logic [7:0] pc_step_s;
  logic       cap0_s;
  logic       cap1_s;
  logic       accept_s;

  logic [1:0] d_opcode_s;
  logic [1:0] d_alu_op_s;
  logic [1:0] d_wr_addr_s;
  logic [1:0] d_rs1_addr_s;
  logic [1:0] d_rs2_addr_s;
  logic [1:0] d_immediate_s;
  logic       d_illegal_s;

  assign pc_plus1_s = pc_r + 8'd1;
  assign pc_step_s  = pc_r + PC_STEP;
  assign cap0_s     = (state_r == F0) && imem_valid;
  assign cap1_s     = (state_r == F1) && imem_valid;
  assign accept_s   = (state_r == ISSUE) && dec_ready;

  // byte1 is taken straight from the memory bus so fields land on ISSUE entry
  instr_decode u_decode (
    .byte0       (byte0_r),
    .byte1       (imem_rdata),
    .opcode      (d_opcode_s),
    .alu_op      (d_alu_op_s),
    .wr_addr     (d_wr_addr_s),
    .rs1_addr    (d_rs1_addr_s),
    .rs2_addr    (d_rs2_addr_s),
    .immediate   (d_immediate_s),
    .dec_illegal (d_illegal_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; redirect overrides every other transition
  always_comb begin
    state_nxt_s = state_r;
    if (redirect) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = F0;
        F0:      state_nxt_s = imem_valid ? F1 : F0;
        F1:      state_nxt_s = imem_valid ? ISSUE : F1;
        ISSUE:   state_nxt_s = dec_ready ? F0 : ISSUE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Memory request decoded from state and pc only
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_r;
    case (state_r)
      F0: begin
        imem_req  = 1'b1;
        imem_addr = pc_r;
      end
      F1: begin
        imem_req  = 1'b1;
        imem_addr = pc_plus1_s;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_r;
      end
    endcase
  end

  // Program counter, byte0 capture and registered decode outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r        <= RESET_PC;
      byte0_r     <= 8'h00;
      dec_valid   <= 1'b0;
      dec_pc      <= 8'h00;
      opcode      <= 2'b00;
      alu_op      <= 2'b00;
      wr_addr     <= 2'b00;
      rs1_addr    <= 2'b00;
      rs2_addr    <= 2'b00;
      immediate   <= 2'b00;
      dec_illegal <= 1'b0;
    end else if (redirect) begin
      // A simultaneous accept in ISSUE still completes; redirect_pc wins the pc
      pc_r      <= redirect_pc;
      byte0_r   <= 8'h00;
      dec_valid <= 1'b0;
    end else begin
      if (cap0_s) begin
        byte0_r <= imem_rdata;
      end
      if (cap1_s) begin
        dec_valid   <= 1'b1;
        dec_pc      <= pc_r;
        opcode      <= d_opcode_s;
        alu_op      <= d_alu_op_s;
        wr_addr     <= d_wr_addr_s;
        rs1_addr    <= d_rs1_addr_s;
        rs2_addr    <= d_rs2_addr_s;
        immediate   <= d_immediate_s;
        dec_illegal <= d_illegal_s;
      end else if (accept_s) begin
        dec_valid <= 1'b0;
        pc_r      <= pc_step_s;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed plus randomized bench for fetch_decode_unit with a wait-state memory
// model and an arithmetic reference decoder.
module tb_fetch_decode_unit;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       dec_valid;
  logic       dec_ready;
  logic [7:0] dec_pc;
  logic [1:0] opcode;
  logic [1:0] alu_op;
  logic [1:0] wr_addr;
  logic [1:0] rs1_addr;
  logic [1:0] rs2_addr;
  logic [1:0] immediate;
  logic       dec_illegal;
  logic       redirect;
  logic [7:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int         mem_wait = 0;
  int         wcnt = 0;
  logic [7:0] pc_model;

  fetch_decode_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .opcode      (opcode),
    .alu_op      (alu_op),
    .wr_addr     (wr_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .immediate   (immediate),
    .dec_illegal (dec_illegal),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: answers after mem_wait cycles of a held request
  always @(posedge clk) begin
    if (imem_req && !imem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_valid = imem_req && (wcnt >= mem_wait);
  assign imem_rdata = imem_req ? mem[imem_addr] : 8'hA5;

  // Reference decode {opcode,alu,wr,rs1,rs2,imm,illegal} by arithmetic on the bytes
  function automatic logic [12:0] model_fields(input logic [7:0] pc);
    logic [7:0] pc1;
    int v0, v1;
    pc1 = pc + 8'd1;
    v0 = int'(mem[pc]);
    v1 = int'(mem[pc1]);
    model_fields = {2'(v0 / 64), 2'((v0 / 16) % 4), 2'((v0 / 4) % 4), 2'(v0 % 4),
                    2'(v1 / 64), 2'((v1 / 16) % 4), 1'((v1 % 16) != 0)};
  endfunction

  function automatic logic [12:0] dut_fields();
    dut_fields = {opcode, alu_op, wr_addr, rs1_addr, rs2_addr, immediate, dec_illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_issue(input string tag, input logic [7:0] pc);
    check({tag, "_valid"}, 32'(dec_valid), 32'd1);
    check({tag, "_pc"}, 32'(dec_pc), 32'(pc));
    check({tag, "_fields"}, 32'(dut_fields()), 32'(model_fields(pc)));
    check({tag, "_noreq"}, 32'(imem_req), 32'd0);
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] addr);
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    check({tag, "_dvalid"}, 32'(dec_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'h00);
    check({tag, "_dvalid"}, 32'(dec_valid), 32'd0);
    check({tag, "_dpc"}, 32'(dec_pc), 32'h00);
    check({tag, "_fields"}, 32'(dut_fields()), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!dec_valid && n < budget) begin
      step();
      n++;
    end
    check("valid_timeout", 32'(dec_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'b01_10_11_00;
    mem[8'h01] = 8'b10_01_0000;
    mem[8'hFF] = 8'h03;
    mem[8'h40] = ~mem[8'h06];
    reset = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;
    #1 check("idle_noreq", 32'(imem_req), 32'd0);
    dec_ready = 1'b1;

    // Zero-wait first instruction
    step(); check_fetch("t1_f0", 8'h00);
    step(); check_fetch("t1_f1", 8'h01);
    step(); check_issue("t1", 8'h00);
    check("t1_opcode", 32'(opcode), 32'd1);
    check("t1_alu", 32'(alu_op), 32'd2);
    check("t1_wr", 32'(wr_addr), 32'd3);
    check("t1_rs1", 32'(rs1_addr), 32'd0);
    check("t1_rs2", 32'(rs2_addr), 32'd2);
    check("t1_imm", 32'(immediate), 32'd1);
    check("t1_illegal", 32'(dec_illegal), 32'd0);
    step(); check_fetch("t1_next", 8'h02);

    // Downstream stall in ISSUE
    dec_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check_issue("t2_hold", 8'h02);
      step();
    end
    check_issue("t2_last", 8'h02);
    dec_ready = 1'b1;
    step(); check_fetch("t2_next", 8'h04);

    // Three wait states on each byte
    dec_ready = 1'b0; mem_wait = 3;
    for (int i = 0; i < 3; i++) begin step(); check_fetch("t3_f0", 8'h04); end
    step(); check_fetch("t3_f1", 8'h05);
    for (int i = 0; i < 3; i++) begin step(); check_fetch("t3_f1w", 8'h05); end
    step(); check_issue("t3", 8'h04);

    // Redirect during F1
    mem_wait = 0; dec_ready = 1'b1;
    step(); check_fetch("t4_f0", 8'h06);
    dec_ready = 1'b0;
    step(); check_fetch("t4_f1", 8'h07);
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    check("t4_bubble_req", 32'(imem_req), 32'd0);
    check("t4_bubble_dv", 32'(dec_valid), 32'd0);
    redirect = 1'b0;
    step(); check_fetch("t4_rf0", 8'h40);
    step(); check_fetch("t4_rf1", 8'h41);
    step(); check_issue("t4", 8'h40);

    // Redirect together with accept in ISSUE
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    check("t5_bubble_req", 32'(imem_req), 32'd0);
    check("t5_bubble_dv", 32'(dec_valid), 32'd0);
    redirect = 1'b0; dec_ready = 1'b0;
    step(); check_fetch("t5_f0", 8'hFE);
    step(); check_fetch("t5_f1", 8'hFF);
    step(); check_issue("t5_fe", 8'hFE);
    check("t5_illegal", 32'(dec_illegal), 32'd1);
    dec_ready = 1'b1;
    step(); check_fetch("t5_wrap", 8'h00);
    redirect = 1'b1; redirect_pc = 8'hFF; dec_ready = 1'b0;
    step(); check("t5_bubble2", 32'(imem_req), 32'd0);
    redirect = 1'b0;
    step(); check_fetch("t5_odd_f0", 8'hFF);
    step(); check_fetch("t5_odd_f1", 8'h00);
    step(); check_issue("t5_ff", 8'hFF);

    // Asynchronous reset in the middle of F1
    dec_ready = 1'b1;
    step(); check_fetch("t6_f0", 8'h01);
    dec_ready = 1'b0;
    step(); check_fetch("t6_f1", 8'h02);
    #2 reset = 1'b0;
    #1 check_reset_state("t6_async");
    @(negedge clk);
    check_reset_state("t6_held");
    reset = 1'b1;
    #1 check("t6_rel_noreq", 32'(imem_req), 32'd0);
    step(); check_fetch("t6_f0b", 8'h00);
    step(); step(); check_issue("t6", 8'h00);

    // Randomized accept/stall/redirect traffic against the reference model
    pc_model = 8'h00;
    for (int k = 0; k < 40; k++) begin
      wait_valid(60);
      check_issue("rnd", pc_model);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        step();
        check_issue("rnd_hold", pc_model);
      end
      mem_wait = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        redirect = 1'b1;
        redirect_pc = 8'($urandom);
        dec_ready = 1'($urandom_range(0, 1));
        pc_model = redirect_pc;
      end else begin
        dec_ready = 1'b1;
        pc_model = pc_model + 8'd2;
      end
      step();
      redirect = 1'b0; dec_ready = 1'b0;
      check("rnd_drop", 32'(dec_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
